// File: rtl/mux_scan.sv
// rtl/mux_scan.sv - registered N-way channel mux with manual select and round-robin auto-scan
module mux_scan #(
  parameter int N  = 8,
  parameter int W  = 1,
  parameter int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  input  logic            en,
  input  logic [SW-1:0]   s,
  input  logic [N*W-1:0]  d,
  output logic [W-1:0]    y,
  output logic            y_valid,
  output logic [SW-1:0]   ch,
  output logic            wrap
);

  typedef enum logic {MANUAL = 1'b0, SCAN = 1'b1} state_t;

  localparam logic [SW:0]   NUM  = (SW+1)'(N);
  localparam logic [SW-1:0] LAST = SW'(N-1);

  state_t        mode_q;
  logic [SW-1:0] cnt;
  logic [W-1:0]  chan [N];

  for (genvar k = 0; k < N; k++) begin : g_chan
    assign chan[k] = d[k*W +: W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MANUAL;
      cnt     <= '0;
      y       <= '0;
      y_valid <= 1'b0;
      ch      <= '0;
      wrap    <= 1'b0;
    end else begin
      y_valid <= en;
      wrap    <= 1'b0;
      if (!mode) begin
        // Manual select; out-of-range indices (non-power-of-2 N) present zero.
        mode_q <= MANUAL;
        cnt    <= '0;
        if (en) begin
          ch <= s;
          y  <= ({1'b0, s} < NUM) ? chan[s] : '0;
        end
      end else begin
        mode_q <= SCAN;
        case (mode_q)
          MANUAL: begin
            // Entering scan: the frame always starts at channel 0.
            if (en) begin
              y    <= chan[0];
              ch   <= '0;
              wrap <= (LAST == '0);
              cnt  <= (LAST == '0) ? '0 : SW'(1);
            end else begin
              cnt  <= '0;
            end
          end
          SCAN: begin
            if (en) begin
              y    <= chan[cnt];
              ch   <= cnt;
              wrap <= (cnt == LAST);
              cnt  <= (cnt == LAST) ? '0 : cnt + SW'(1);
            end
          end
          default: cnt <= '0;
        endcase
      end
    end
  end

endmodule
